// File: rtl/pdm_cic_decim.sv
// Third-order CIC decimator turning a 1-bit PDM stream into signed 16-bit PCM.
// Integrators run at the strobe rate; combs and the output stage run once per 64 strobes.
module pdm_cic_decim #(
  parameter int DECIM = 64,
  parameter int ORDER = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pdm_data,
  input  logic        pdm_valid,
  output logic [15:0] pcm_data,
  output logic        pcm_valid,
  output logic        pcm_sat
);

  localparam int PH_W  = $clog2(DECIM);
  localparam int ACC_W = 1 + ORDER * PH_W;
  localparam logic signed [ACC_W:0] CENTRE = (ACC_W+1)'(1 << (ACC_W - 2));

  logic [ACC_W-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [ACC_W-1:0] comb1_p0_q, comb1_p0_d, dly1_q, dly1_d;
  logic [ACC_W-1:0] comb2_p1_q, comb2_p1_d, dly2_q, dly2_d;
  logic [ACC_W-1:0] dly3_q, dly3_d;
  logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [15:0]      pcm_data_q, pcm_data_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             pcm_sat_q, pcm_sat_d;
  logic             block_end;
  logic [ACC_W-1:0] comb3;
  logic signed [16:0] shifted;

  // Comb output is unsigned 0..2^18; re-centre around zero and drop two bits.
  function automatic logic signed [16:0] centre_shift(input logic [ACC_W-1:0] x);
    logic signed [ACC_W:0] c;
    c = $signed({1'b0, x}) - CENTRE;
    return 17'(c >>> 2);
  endfunction

  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) return 16'h7FFF;
    return 16'(v);
  endfunction

  always_comb begin
    int1_d      = int1_q;
    int2_d      = int2_q;
    int3_d      = int3_q;
    phase_d     = phase_q;
    comb1_p0_d  = comb1_p0_q;
    dly1_d      = dly1_q;
    comb2_p1_d  = comb2_p1_q;
    dly2_d      = dly2_q;
    dly3_d      = dly3_q;
    pcm_data_d  = pcm_data_q;
    pcm_sat_d   = pcm_sat_q;
    block_end   = pdm_valid && (phase_q == PH_W'(DECIM - 1));

    // stage p0: integrate the strobe, snapshot integrator 3 at block end into comb 1
    if (pdm_valid) begin
      int1_d  = int1_q + ACC_W'(pdm_data);
      int2_d  = int2_q + int1_d;
      int3_d  = int3_q + int2_d;
      phase_d = phase_q + PH_W'(1);
    end
    vld_p0_d = block_end;
    if (block_end) begin
      comb1_p0_d = int3_d - dly1_q;
      dly1_d     = int3_d;
    end

    // stage p1: second comb
    vld_p1_d = vld_p0_q;
    if (vld_p0_q) begin
      comb2_p1_d = comb1_p0_q - dly2_q;
      dly2_d     = comb1_p0_q;
    end

    // stage p2: third comb, centring, saturation into the output register
    comb3       = comb2_p1_q - dly3_q;
    shifted     = centre_shift(comb3);
    pcm_valid_d = vld_p1_q;
    if (vld_p1_q) begin
      dly3_d     = comb2_p1_q;
      pcm_data_d = sat16(shifted);
      if (shifted > 17'sd32767) pcm_sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int1_q      <= '0;
      int2_q      <= '0;
      int3_q      <= '0;
      phase_q     <= '0;
      comb1_p0_q  <= '0;
      dly1_q      <= '0;
      comb2_p1_q  <= '0;
      dly2_q      <= '0;
      dly3_q      <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      pcm_sat_q   <= 1'b0;
    end else begin
      int1_q      <= int1_d;
      int2_q      <= int2_d;
      int3_q      <= int3_d;
      phase_q     <= phase_d;
      comb1_p0_q  <= comb1_p0_d;
      dly1_q      <= dly1_d;
      comb2_p1_q  <= comb2_p1_d;
      dly2_q      <= dly2_d;
      dly3_q      <= dly3_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_sat_q   <= pcm_sat_d;
    end
  end

  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;
  assign pcm_sat   = pcm_sat_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Scoreboard bench for pdm_cic_decim: a direct-convolution CIC model predicts each PCM
// sample and the cycle it must appear on; a negedge monitor pops and compares.
module tb_pdm_cic_decim;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pdm_data = 1'b0;
  logic        pdm_valid = 1'b0;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        pcm_sat;

  pdm_cic_decim #(.DECIM(64), .ORDER(3)) dut (
    .clk(clk), .reset(reset), .pdm_data(pdm_data), .pdm_valid(pdm_valid),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_sat(pcm_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  typedef struct {int data; int sat; int cyc;} exp_t;
  exp_t sb[$];

  int          h[190];
  logic [189:0] hist;
  int          phase;
  int          model_sat = 0;
  int          last_pcm = 0;
  int          n_pulse = 0;
  int          cap[$];

  // Exact CIC response: y[n] = sum_k h[k]*x[n-k], h = box64 * box64 * box64.
  function automatic exp_t predict(input int now);
    exp_t e;
    int y, v, s;
    y = 0;
    for (int k = 0; k < 190; k++) if (hist[k]) y += h[k];
    v = y - 131072;
    s = v >>> 2;
    e.sat  = (s == 32768) ? 1 : 0;
    e.data = (s == 32768) ? 32767 : s;
    e.cyc  = now + 3;
    return e;
  endfunction

  // Called at a negedge; leaves at a negedge after `gap` clocks.
  task automatic send(input logic b, input int gap);
    pdm_valid = 1'b1;
    pdm_data  = b;
    hist  = {hist[188:0], b};
    phase = phase + 1;
    if (phase == 64) begin
      phase = 0;
      sb.push_back(predict(cyc));
    end
    @(negedge clk);
    pdm_valid = 1'b0;
    pdm_data  = 1'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    hist  = '0;
    phase = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_pcm  = 0;
      model_sat = 0;
    end else if (pcm_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pcm_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pcm_data", int'($signed(pcm_data)), e.data);
        check("pcm_latency_cycle", cyc, e.cyc);
        if (e.sat != 0) model_sat = 1;
        check("pcm_sat", int'(pcm_sat), model_sat);
      end
      cap.push_back(int'($signed(pcm_data)));
      last_pcm = int'($signed(pcm_data));
      n_pulse++;
    end else begin
      check("pcm_hold", int'($signed(pcm_data)), last_pcm);
    end
  end

  logic pat[640];
  int   ref_seq[$];
  int   p0;

  initial begin
    for (int k = 0; k < 190; k++) h[k] = 0;
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++)
        for (int c = 0; c < 64; c++) h[a+b+c]++;
    hist = '0;
    phase = 0;

    repeat (3) @(negedge clk);
    check("reset_pcm_data", int'(pcm_data), 0);
    check("reset_pcm_valid", int'(pcm_valid), 0);
    check("reset_pcm_sat", int'(pcm_sat), 0);
    reset = 1'b0;
    @(negedge clk);

    // all zeros
    p0 = n_pulse;
    for (int i = 0; i < 640; i++) send(1'b0, 1);
    drain();
    check("zeros_pulse_count", n_pulse - p0, 10);
    check("zeros_last_data", int'($signed(pcm_data)), -32768);
    check("zeros_sat", int'(pcm_sat), 0);

    // all ones
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 640; i++) send(1'b1, 1);
    drain();
    check("ones_pulse_count", n_pulse - p0, 10);
    check("ones_last_data", int'($signed(pcm_data)), 32767);
    check("ones_sat", int'(pcm_sat), 1);

    // 50% density
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 640; i++) send((i % 2) == 0, 2);
    drain();
    check("half_pulse_count", n_pulse - p0, 10);
    check("half_last_data", int'($signed(pcm_data)), 0);
    check("half_sat", int'(pcm_sat), 0);

    // same random bits, dense vs sparse strobes
    for (int i = 0; i < 640; i++) pat[i] = 1'($urandom);
    do_reset();
    cap.delete();
    for (int i = 0; i < 640; i++) send(pat[i], 1);
    drain();
    ref_seq = cap;
    do_reset();
    cap.delete();
    for (int i = 0; i < 640; i++) send(pat[i], 50);
    drain();
    check("gap_count_dense", ref_seq.size(), 10);
    check("gap_count_sparse", cap.size(), 10);
    for (int i = 0; i < 10 && i < cap.size() && i < ref_seq.size(); i++)
      check("gap_seq_equal", cap[i], ref_seq[i]);

    // back-to-back strobes
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 256; i++) send(1'($urandom), 1);
    drain();
    check("b2b_pulse_count", n_pulse - p0, 4);

    // reset with a result in flight and sat set
    do_reset();
    for (int i = 0; i < 256; i++) send(1'b1, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    hist  = '0;
    phase = 0;
    #1;
    check("async_pcm_data", int'(pcm_data), 0);
    check("async_pcm_valid", int'(pcm_valid), 0);
    check("async_pcm_sat", int'(pcm_sat), 0);
    p0 = n_pulse;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("discarded_pulses", n_pulse - p0, 0);
    for (int i = 0; i < 64; i++) send(1'($urandom), 3);
    drain();
    check("post_reset_pulses", n_pulse - p0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decim.md
PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 The module SHALL have parameter DECIM, default 64, meaning the decimation ratio; 64 is the only supported value.
REQ-002 The module SHALL have parameter ORDER, default 3, meaning the number of CIC stages; 3 is the only supported value.
REQ-003 Port clk SHALL be an input, 1 bit: the system clock (100 MHz); all logic is on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port pdm_data SHALL be an input, 1 bit: microphone PDM bit, valid when pdm_valid=1.
REQ-006 Port pdm_valid SHALL be an input, 1 bit: single-clk strobe, one per PDM bit; arbitrary gaps allowed.
REQ-007 Port pcm_data SHALL be an output, 16 bits: signed two's-complement PCM sample.
REQ-008 Port pcm_valid SHALL be an output, 1 bit: single-clk pulse; pcm_data is new in that cycle.
REQ-009 Port pcm_sat SHALL be an output, 1 bit: sticky flag set when any output sample was saturated.

Function
REQ-010 Input mapping SHALL be: pdm_data=1 -> +1, pdm_data=0 -> 0, unsigned, into a 19-bit datapath.
REQ-011 Three cascaded integrators SHALL each be 19 bits wide, use modular (wrapping) arithmetic, and update only in cycles with pdm_valid=1.
REQ-012 A 6-bit phase counter SHALL increment on each pdm_valid and wrap 63 -> 0.
REQ-013 The pdm_valid that brings the counter from 63 to 0 SHALL latch integrator-3 output (the value after that sample is accumulated) as the decimated sample.
REQ-014 Decimated samples SHALL pass through three registered comb stages, each y = x - x_prev, 19 bits wide, wrapping, with x_prev updated only on decimated samples.
REQ-015 The comb result (unsigned 0..262144) SHALL be centred by subtracting 131072, then arithmetically shifted right by 2.
REQ-016 A centred and shifted value of +32768 SHALL saturate to 32767 and set pcm_sat; -32768 is passed unchanged.
REQ-017 pcm_valid SHALL pulse exactly 2 clk cycles after the rising edge that sampled the 64th pdm_valid of a block.
REQ-018 pcm_data SHALL hold its value between pulses.
REQ-019 Latency SHALL be independent of gaps in pdm_valid; output values SHALL depend only on the sequence of pdm_data bits.
REQ-020 A pdm_valid arriving while a comb computation is in flight SHALL be accepted with no loss or stall; the pipeline never back-pressures.
REQ-021 Throughput SHALL be one PCM sample per 64 pdm_valid strobes; the minimum pdm_valid spacing is 1 clk.
REQ-022 The first 2 PCM samples after reset SHALL be treated as filter-settling transients; from the 3rd sample onward, output SHALL equal the exact CIC response.
REQ-023 pdm_data SHALL be ignored in cycles where pdm_valid=0.

Reset
REQ-024 While reset=1, integrators, comb registers, comb delay registers, and the phase counter SHALL be 0.
REQ-025 While reset=1, pcm_data SHALL be 0, pcm_valid SHALL be 0, and pcm_sat SHALL be 0.
REQ-026 Reset asserted mid-block SHALL discard the partial block and any in-flight comb result; no pcm_valid occurs for them.
REQ-027 After reset deasserts, the first pdm_valid SHALL be phase 0 of a new block.
REQ-028 pcm_sat SHALL be cleared only by reset.

Verification
REQ-029 Reset test: assert reset mid-operation -> all outputs 0 asynchronously; after release, the next pcm_valid occurs exactly 2 cycles after the 64th new pdm_valid.
REQ-030 All-zero test: 640 strobes with pdm_data=0 -> 10 pcm_valid pulses, each pcm_data=-32768, pcm_sat=0.
REQ-031 All-ones test: 640 strobes with pdm_data=1 -> from the 3rd sample onward pcm_data=32767, and pcm_sat=1 after the 3rd sample.
REQ-032 50% density test: 1,0,1,0,... for 640 strobes -> from the 3rd sample onward pcm_data=0, pcm_sat=0.
REQ-033 Gapped-strobe test: random pattern, pdm_valid every 1 vs every 50 clks -> identical pcm_data sequences; each pcm_valid exactly 2 clks after its 64th strobe.
REQ-034 Back-to-back test: pdm_valid held high continuously for 256 clks -> exactly 4 pcm_valid pulses, spaced 64 clks apart.
